uart_tx: RTL and testbench

- 8-bit UART transmitter; the send side of the serial link whose receive side samples each bit after 8 clocks.
- Accepts a byte over a valid/ready handshake and serialises it on tx_out: start bit, 8 data bits LSB first, optional parity, one stop bit.
- One-entry holding register, so a second byte can be queued while the first is shifting out; back-to-back frames have no idle gap.
- Sits between the RISC-V core's UART peripheral register interface and the tx pin.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam logic        UART_IDLE_LEVEL   = 1'b1;
    localparam int unsigned UART_CLKS_PER_BIT = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each serial bit.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int unsigned          CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]        LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign bit_end = enable && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= bit_end ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter with a one-entry holding register: start bit,
// LSB-first data, optional parity, one stop bit; registered line output.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       t_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned IW       = $clog2(UART_DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(UART_DATA_BITS - 1);
    localparam logic        LP_PAR_EN  = (PARITY_EN != 0);
    localparam logic        LP_PAR_ODD = (PARITY_ODD != 0);

    uart_state_t r_state, w_state_next;

    logic [7:0]    r_hold;
    logic          r_hold_full;
    logic [7:0]    r_shift;
    logic [IW-1:0] r_index;
    logic          r_tx_out;
    logic          r_done;

    logic w_bit_end;
    logic w_accept;
    logic w_load;
    logic w_tx_next;
    logic w_done_next;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (t_clk),
        .reset  (reset),
        .clear  (r_state == IDLE),
        .enable (r_state != IDLE),
        .bit_end(w_bit_end)
    );

    assign w_accept = tx_valid && !r_hold_full;
    assign w_load   = r_hold_full &&
                      ((r_state == IDLE) || (r_state == STOP && w_bit_end));

    assign tx_ready = !r_hold_full;
    assign tx_busy  = (r_state != IDLE) || r_hold_full;
    assign tx_out   = r_tx_out;
    assign tx_done  = r_done;

    always_ff @(posedge t_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (r_hold_full) w_state_next = START;
            START:  if (w_bit_end) w_state_next = DATA;
            DATA:   if (w_bit_end && r_index == LAST_IDX)
                        w_state_next = LP_PAR_EN ? PARITY : STOP;
            PARITY: if (w_bit_end) w_state_next = STOP;
            STOP:   if (w_bit_end) w_state_next = r_hold_full ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Line level and done are computed from the current state and then
    // registered, so the pin lags the state by one cycle.
    always_comb begin
        w_tx_next   = UART_IDLE_LEVEL;
        w_done_next = 1'b0;
        case (r_state)
            START:  w_tx_next = 1'b0;
            DATA:   w_tx_next = r_shift[r_index];
            PARITY: w_tx_next = (^r_shift) ^ LP_PAR_ODD;
            STOP: begin
                w_tx_next   = 1'b1;
                w_done_next = w_bit_end;
            end
            default: w_tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge t_clk) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_index     <= '0;
            r_tx_out    <= UART_IDLE_LEVEL;
            r_done      <= 1'b0;
        end else begin
            r_tx_out <= w_tx_next;
            r_done   <= w_done_next;
            if (w_load) begin
                r_shift <= r_hold;
            end
            if (w_accept) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (r_state == START) begin
                r_index <= '0;
            end else if (r_state == DATA && w_bit_end) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no parity, even, odd) sharing
// clock and reset; line samples are recorded and decoded per frame.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] data  [3];
    logic       valid [3];
    logic       ready [3];
    logic       out   [3];
    logic       busy  [3];
    logic       done  [3];

    logic rec_line  [0:400];
    logic rec_done  [0:400];
    logic rec_ready [0:400];

    int pass_cnt = 0;
    int tot_cnt  = 0;

    uart_tx #(.CLKS_PER_BIT(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .t_clk(clk), .reset(reset), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    uart_tx #(.CLKS_PER_BIT(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .t_clk(clk), .reset(reset), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1]));

    uart_tx #(.CLKS_PER_BIT(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .t_clk(clk), .reset(reset), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Waits (bounded) for tx_ready, then presents the byte for one accept edge.
    task automatic send(input int k, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!ready[k] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, ready[k]}, 32'd1);
        data[k]  = b;
        valid[k] = 1'b1;
        @(posedge clk);
        #1 valid[k] = 1'b0;
    endtask

    // Called right after the accept edge N; line cycle c spans edges N+1+c..N+2+c.
    task automatic record(input int k, input int n);
        @(negedge clk);
        check("lat_pre1", {31'd0, out[k]}, 32'd1);
        @(negedge clk);
        check("lat_pre2", {31'd0, out[k]}, 32'd1);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            rec_line[c]  = out[k];
            rec_done[c]  = done[k];
            rec_ready[c] = ready[k];
        end
    endtask

    task automatic check_frame(input string tag, input int off, input int nb,
                               input logic [7:0] exp, input logic pexp);
        logic [10:0] bits;
        logic [7:0]  got;
        int err = 0;
        int ndone = 0;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = exp;
        if (nb == 11) bits[9] = pexp;
        for (int b = 0; b < nb; b++)
            for (int s = 0; s < 8; s++)
                if (rec_line[off + b*8 + s + 1] !== bits[b]) err++;
        check({tag, "_bit_errs"}, err, 0);
        for (int i = 0; i < 8; i++) got[i] = rec_line[off + (i+1)*8 + 4];
        check({tag, "_byte"}, {24'd0, got}, {24'd0, exp});
        for (int c = off + 1; c <= off + nb*8; c++) ndone += int'(rec_done[c]);
        check({tag, "_done_cnt"}, ndone, 1);
        check({tag, "_done_pos"}, {31'd0, rec_done[off + nb*8]}, 32'd1);
    endtask

    initial begin
        logic [9:0] pat;
        int ndone;
        int nlow;

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data[k]  = 8'h00;
            valid[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        ndone = 0;
        nlow  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ndone += int'(done[0]);
            nlow  += int'(!out[0]);
        end
        check("idle_out",   {31'd0, out[0]},   32'd1);
        check("idle_ready", {31'd0, ready[0]}, 32'd1);
        check("idle_busy",  {31'd0, busy[0]},  32'd0);
        check("idle_done_cnt", ndone, 0);
        check("idle_low_cnt",  nlow,  0);

        // Single byte 0xA5.
        send(0, 8'hA5);
        record(0, 90);
        for (int b = 0; b < 10; b++) pat[b] = rec_line[b*8 + 4];
        check("a5_pattern", {22'd0, pat}, {22'd0, 10'b1101001010});
        check_frame("a5", 0, 10, 8'hA5, 1'b0);
        check("a5_idle_after", {31'd0, rec_line[85]}, 32'd1);

        // Back-to-back 0x55 then 0x0F.
        fork
            begin
                send(0, 8'h55);
                record(0, 170);
            end
            begin
                repeat (35) @(negedge clk);
                send(0, 8'h0F);
            end
        join
        nlow = 0;
        for (int c = 40; c <= 79; c++) nlow += int'(rec_ready[c]);
        check("b2b_ready_low", nlow, 0);
        check("b2b_ready_reload", {31'd0, rec_ready[80]}, 32'd1);
        check("b2b_gap_start", {31'd0, rec_line[81]}, 32'd0);
        check_frame("b2b0", 0, 10, 8'h55, 1'b0);
        check_frame("b2b1", 80, 10, 8'h0F, 1'b0);

        // Parity even and odd on 0x07.
        send(1, 8'h07);
        record(1, 95);
        check("par_even_bit", {31'd0, rec_line[9*8 + 4]}, 32'd1);
        check_frame("par_even", 0, 11, 8'h07, 1'b1);
        send(2, 8'h07);
        record(2, 95);
        check("par_odd_bit", {31'd0, rec_line[9*8 + 4]}, 32'd0);
        check_frame("par_odd", 0, 11, 8'h07, 1'b0);

        // Reset during data bit 3 of 0xFF with 0x11 queued.
        send(0, 8'hFF);
        repeat (5) @(negedge clk);
        send(0, 8'h11);
        repeat (30) @(negedge clk);
        check("mid_out",   {31'd0, out[0]},   32'd1);
        check("mid_ready", {31'd0, ready[0]}, 32'd0);
        check("mid_busy",  {31'd0, busy[0]},  32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out",   {31'd0, out[0]},   32'd1);
        check("rst_ready", {31'd0, ready[0]}, 32'd1);
        check("rst_busy",  {31'd0, busy[0]},  32'd0);
        reset = 1'b0;
        ndone = 0;
        nlow  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ndone += int'(done[0]);
            nlow  += int'(!out[0]);
        end
        check("rst_no_frame_low",  nlow,  0);
        check("rst_no_frame_done", ndone, 0);
        send(0, 8'h3C);
        record(0, 85);
        check_frame("after_rst", 0, 10, 8'h3C, 1'b0);

        // Stream of four bytes decoded in order.
        fork
            begin
                send(0, 8'h00);
                record(0, 330);
            end
            begin
                repeat (3) @(negedge clk);
                send(0, 8'hFF);
                send(0, 8'h80);
                send(0, 8'h01);
            end
        join
        check_frame("lb0", 0,   10, 8'h00, 1'b0);
        check_frame("lb1", 80,  10, 8'hFF, 1'b0);
        check_frame("lb2", 160, 10, 8'h80, 1'b0);
        check_frame("lb3", 240, 10, 8'h01, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
